// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RISC-V control unit.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package multicycle_pkg;

  // FSM state codes; they also appear on the debug state output.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_EXECU    = 4'd11
  } state_t;

  // Opcode field values
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // aluSrcA select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // aluSrcB select
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // resultSrc select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // immSrc format
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // aluOp
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

endpackage

// File: rtl/imm_src_deco.sv
// Immediate-format decode from the opcode field.
// Latency: purely combinational, same cycle.
// Backpressure: none; output follows op_i every cycle.
module imm_src_deco
  import multicycle_pkg::*;
#(
  parameter int ENABLE_UTYPE = 1
) (
  input  logic [6:0] op_i,
  output logic [2:0] imm_src_o
);

  // Map opcode to immediate format; unknown or disabled opcodes give I.
  always_comb begin
    imm_src_o = IMM_I;
    case (op_i)
      OP_STORE:  imm_src_o = IMM_S;
      OP_BRANCH: imm_src_o = IMM_B;
      OP_JAL:    imm_src_o = IMM_J;
      OP_LUI,
      OP_AUIPC:  imm_src_o = (ENABLE_UTYPE != 0) ? IMM_U : IMM_I;
      default:   imm_src_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle RISC-V datapath (lw/sw/R/I/U/jal/beq).
// Latency: lw 5, sw 4, R/I/U 4, jal 4, beq 3 cycles with memory always ready.
// Backpressure: FETCH, MEMREAD and MEMWRITE stall on memRdy=0 when MEM_HANDSHAKE=1.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int ENABLE_UTYPE  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       memRdy,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] immSrc,
  output logic [1:0] aluOp,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q, state_d;
  logic   mem_rdy;

  // Without the handshake every memory access is taken to finish in one cycle.
  assign mem_rdy = (MEM_HANDSHAKE != 0) ? memRdy : 1'b1;

  imm_src_deco #(
    .ENABLE_UTYPE(ENABLE_UTYPE)
  ) u_imm_src_deco (
    .op_i      (op),
    .imm_src_o (immSrc)
  );

  // State register; synchronous reset returns to FETCH from any point.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore outputs; reset masks everything to idle FETCH values.
  always_comb begin
    state_d   = S_FETCH;
    pcWrite   = 1'b0;
    adrSrc    = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    regWrite  = 1'b0;
    resultSrc = RES_ALUOUT;
    aluSrcA   = SRCA_PC;
    aluSrcB   = SRCB_RS2;
    aluOp     = ALUOP_ADD;
    illegal   = 1'b0;
    state     = state_q;

    case (state_q)
      S_FETCH: begin
        adrSrc    = 1'b0;
        aluSrcA   = SRCA_PC;
        aluSrcB   = SRCB_FOUR;
        aluOp     = ALUOP_ADD;
        resultSrc = RES_ALURES;
        irWrite   = mem_rdy;
        pcWrite   = mem_rdy;
        state_d   = mem_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        aluOp   = ALUOP_ADD;
        case (op)
          OP_LOAD,
          OP_STORE:  state_d = S_MEMADR;
          OP_RTYPE:  state_d = S_EXECR;
          OP_ITYPE:  state_d = S_EXECI;
          OP_BRANCH: state_d = S_BEQ;
          OP_JAL:    state_d = S_JAL;
          OP_LUI,
          OP_AUIPC: begin
            if (ENABLE_UTYPE != 0) begin
              state_d = S_EXECU;
            end else begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          end
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        aluOp   = ALUOP_ADD;
        state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrSrc  = 1'b1;
        state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        resultSrc = RES_DATA;
        regWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        adrSrc   = 1'b1;
        memWrite = 1'b1;
        state_d  = mem_rdy ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_RS2;
        aluOp   = ALUOP_FUNC;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        aluOp   = ALUOP_FUNC;
        state_d = S_ALUWB;
      end
      S_EXECU: begin
        // lui adds the immediate to zero, auipc adds it to the instruction's PC
        aluSrcA = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        aluOp   = ALUOP_ADD;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        resultSrc = RES_ALUOUT;
        regWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        aluSrcA   = SRCA_OLDPC;
        aluSrcB   = SRCB_FOUR;
        aluOp     = ALUOP_ADD;
        resultSrc = RES_ALUOUT;
        pcWrite   = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        aluSrcA   = SRCA_RS1;
        aluSrcB   = SRCB_RS2;
        aluOp     = ALUOP_SUB;
        resultSrc = RES_ALUOUT;
        pcWrite   = zero;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (reset) begin
      pcWrite   = 1'b0;
      irWrite   = 1'b0;
      memWrite  = 1'b0;
      regWrite  = 1'b0;
      illegal   = 1'b0;
      adrSrc    = 1'b0;
      aluSrcA   = SRCA_PC;
      aluSrcB   = SRCB_FOUR;
      aluOp     = ALUOP_ADD;
      resultSrc = RES_ALURES;
      state     = S_FETCH;
    end
  end

endmodule
